fp_mul_booth_seq: RTL and testbench

//  Sequential radix-4 Booth significand multiplier for the FP32 multiply path.

---
 rtl/fp_mul_booth_seq.sv | 122 ++++++++++++
 tb/tb_fp_mul_booth_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_booth_seq.sv
// fp_mul_booth_seq: sequential radix-4 Booth significand multiplier for FP32 multiply.
// Restores the hidden bits and forms the unsigned product {1,frc_X}*{1,frc_Y},
// retiring one Booth digit per cycle. Subnormal/zero operands take a 1-cycle flush path.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is combinational (state==IDLE)
//   frc_X, frc_Y          23-bit fractions (hidden bit implied)
//   Xsub, Ysub            exponent field zero -> product flushed to zero
//   sign_in               product sign, carried through to sign_Z
//   out_valid / out_ready result handshake
//   frc_Z_full            48-bit unsigned significand product
//   sign_Z                registered copy of sign_in
module fp_mul_booth_seq #(
  parameter int unsigned MAN_W = 24,
  parameter int unsigned DIG_N = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN_W-2:0]   frc_X,
  input  logic [MAN_W-2:0]   frc_Y,
  input  logic               Xsub,
  input  logic               Ysub,
  input  logic               sign_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MAN_W-1:0] frc_Z_full,
  output logic               sign_Z
);

  localparam int unsigned PRD_W = 2 * MAN_W;
  localparam int unsigned M_W   = MAN_W + 2;
  localparam int unsigned Q_W   = MAN_W + 3;
  localparam int unsigned PP_W  = MAN_W + 4;
  localparam int unsigned LO_W  = 2 * DIG_N;
  localparam int unsigned ACC_W = LO_W + PP_W;
  localparam int unsigned CNT_W = $clog2(DIG_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIG_N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [M_W-1:0]     m;
  logic [Q_W-1:0]     q;
  logic [ACC_W-1:0]   acc, acc_nx;
  logic [CNT_W-1:0]   cnt;
  logic [PP_W-1:0]    m_ext, pp, sum_hi;

  assign in_ready = (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (Xsub | Ysub) ? DONE : BUSY;
      BUSY:    if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Booth digit recode of Q[2:0] and partial-product add into the accumulator top;
  // the combined accumulator then shifts right by 2 with sign extension.
  always_comb begin
    m_ext = PP_W'(m);
    pp    = '0;
    case (q[2:0])
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum_hi = acc[ACC_W-1 -: PP_W] + pp;
    acc_nx = {{2{sum_hi[PP_W-1]}}, sum_hi, acc[LO_W-1:2]};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m          <= '0;
      q          <= '0;
      acc        <= '0;
      cnt        <= '0;
      frc_Z_full <= '0;
      sign_Z     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= (state_nx == DONE);
      case (state)
        IDLE: if (in_valid) begin
          m      <= {2'b00, 1'b1, frc_X};
          q      <= {2'b00, 1'b1, frc_Y, 1'b0};
          sign_Z <= sign_in;
          acc    <= '0;
          cnt    <= '0;
          if (Xsub | Ysub) frc_Z_full <= '0;
        end
        BUSY: begin
          acc <= acc_nx;
          q   <= {{2{q[Q_W-1]}}, q[Q_W-1:2]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) frc_Z_full <= acc_nx[PRD_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Shifted-out bits are always zero, and the final product fits in PRD_W bits.
  prod_guard_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state == BUSY) |-> (acc[1:0] == 2'b00 &&
                         (cnt != LAST || acc_nx[ACC_W-1:PRD_W] == '0)));

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Testbench for fp_mul_booth_seq: scoreboard of expected products pushed at accept,
// popped and compared when out_valid appears.
module tb_fp_mul_booth_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] frc_X = '0;
  logic [22:0] frc_Y = '0;
  logic        Xsub = 1'b0;
  logic        Ysub = 1'b0;
  logic        sign_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] frc_Z_full;
  logic        sign_Z;

  typedef struct packed {
    logic [47:0] prd;
    logic        sgn;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fp_mul_booth_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .frc_X(frc_X), .frc_Y(frc_Y), .Xsub(Xsub), .Ysub(Ysub), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .frc_Z_full(frc_Z_full), .sign_Z(sign_Z)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [22:0] fx, input logic [22:0] fy,
                                 input logic xs, input logic ys, input logic sg);
    exp_t e;
    e.sgn = sg;
    if (xs | ys) e.prd = '0;
    else         e.prd = 48'({1'b1, fx}) * 48'({1'b1, fy});
    return e;
  endfunction

  // Hold-stability monitor: a stalled result must not change until accepted.
  logic        hold_q = 1'b0;
  logic [47:0] hold_z = '0;
  logic        hold_s = 1'b0;
  always @(posedge clk) begin
    hold_q <= rst_n && out_valid && !out_ready;
    hold_z <= frc_Z_full;
    hold_s <= sign_Z;
  end
  always @(negedge clk) begin
    if (hold_q && rst_n) begin
      checks++;
      if (!out_valid || frc_Z_full !== hold_z || sign_Z !== hold_s) begin
        errors++;
        $display("FAIL hold_stable: got valid=%0b z=%h s=%0b, need valid=1 z=%h s=%0b",
                 out_valid, frc_Z_full, sign_Z, hold_z, hold_s);
      end
    end
  end

  // Drive one operand bundle, wait for acceptance, push the expectation.
  task automatic send(input logic [22:0] fx, input logic [22:0] fy,
                      input logic xs, input logic ys, input logic sg);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; frc_X = fx; frc_Y = fy; Xsub = xs; Ysub = ys; sign_in = sg;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, need 1", in_ready, n);
    end else begin
      sb.push_back(model(fx, fy, xs, ys, sg));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; frc_X = 'x; frc_Y = 'x; Xsub = 1'b0; Ysub = 1'b0; sign_in = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen (1 = first cycle after).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || frc_Z_full !== 48'h0 || sign_Z !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b z=%h s=%0b, need 0/0/0",
               out_valid, frc_Z_full, sign_Z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, need 1", in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_directed;
    logic [22:0] tx[4];
    logic [22:0] ty[4];
    logic [47:0] tz[4];
    int lat;
    exp_t e;
    tx = '{23'h000000, 23'h400000, 23'h000000, 23'h7FFFFF};
    ty = '{23'h000000, 23'h400000, 23'h490FDB, 23'h7FFFFF};
    tz = '{48'h400000000000, 48'h900000000000, 48'h6487ED800000, 48'hFFFFFE000001};
    for (int i = 0; i < 4; i++) begin
      send(tx[i], ty[i], 1'b0, 1'b0, 1'(i & 1));
      wait_valid(lat);
      checks++;
      if (lat != 14) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, need 14", i, lat);
      end
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (frc_Z_full !== tz[i] || sign_Z !== e.sgn) begin
          errors++;
          $display("FAIL directed_product[%0d]: got %h s=%0b, need %h s=%0b",
                   i, frc_Z_full, sign_Z, tz[i], e.sgn);
        end
        checks++;
        if (frc_Z_full !== e.prd) begin
          errors++;
          $display("FAIL directed_scoreboard[%0d]: got %h, need %h", i, frc_Z_full, e.prd);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush;
    int lat;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      send(23'h5A5A5A, 23'h123456, 1'(i == 0), 1'(i == 1), 1'b1);
      wait_valid(lat);
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL flush_latency[%0d]: got %0d, need 1", i, lat);
      end
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (frc_Z_full !== 48'h0 || sign_Z !== 1'b1 || e.prd !== frc_Z_full) begin
          errors++;
          $display("FAIL flush_result[%0d]: got %h s=%0b, need 0 s=1", i, frc_Z_full, sign_Z);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure_abort;
    int lat;
    int seen;
    exp_t e;
    e = '0;
    out_ready = 1'b0;
    send(23'h2AAAAA, 23'h555555, 1'b0, 1'b0, 1'b1);
    wait_valid(lat);
    if (sb.size() > 0) e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || frc_Z_full !== e.prd || sign_Z !== e.sgn) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%0b r=%0b z=%h s=%0b, need v=1 r=0 z=%h s=%0b",
                 c, out_valid, in_ready, frc_Z_full, sign_Z, e.prd, e.sgn);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%0b r=%0b, need v=0 r=1", out_valid, in_ready);
    end
    // Second op is aborted by reset mid-BUSY.
    send(23'h1FFFFF, 23'h0F0F0F, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frc_Z_full !== 48'h0) begin
      errors++;
      $display("FAIL abort_reset: got v=%0b r=%0b z=%h, need v=0 r=1 z=0",
               out_valid, in_ready, frc_Z_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got valid cycles=%0d r=%0b, need 0 and r=1", seen, in_ready);
    end
  endtask

  task automatic test_random;
    int lat;
    exp_t e;
    logic [22:0] fx, fy;
    logic xs, ys;
    for (int i = 0; i < 24; i++) begin
      fx = 23'($urandom);
      fy = 23'($urandom);
      xs = ($urandom_range(0, 7) == 0);
      ys = ($urandom_range(0, 7) == 0);
      send(fx, fy, xs, ys, 1'($urandom));
      wait_valid(lat);
      checks++;
      if (!out_valid || sb.size() == 0) begin
        errors++;
        $display("FAIL random_timeout[%0d]: out_valid=%0b, need 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        if (frc_Z_full !== e.prd || sign_Z !== e.sgn ||
            lat != ((xs | ys) ? 1 : 14) ||
            (!(xs | ys) && frc_Z_full[47:46] == 2'b00)) begin
          errors++;
          $display("FAIL random[%0d]: got %h s=%0b lat=%0d, need %h s=%0b lat=%0d",
                   i, frc_Z_full, sign_Z, lat, e.prd, e.sgn, (xs | ys) ? 1 : 14);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(23'($urandom), 23'($urandom), 1'b0, 1'b0, 1'(i & 1));
      end
      begin
        int lat;
        exp_t e;
        for (int j = 0; j < 6; j++) begin
          wait_valid(lat);
          checks++;
          if (!out_valid || sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_timeout[%0d]: out_valid=%0b, need 1", j, out_valid);
          end else begin
            e = sb.pop_front();
            if (frc_Z_full !== e.prd || sign_Z !== e.sgn) begin
              errors++;
              $display("FAIL b2b[%0d]: got %h s=%0b, need %h s=%0b",
                       j, frc_Z_full, sign_Z, e.prd, e.sgn);
            end
          end
          @(posedge clk);
          #1;
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_backpressure_abort();
    test_random();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
